fifo_stream_reader: RTL and testbench

//  Read-side consumer for the 8-bit synchronous FIFO: drives its rd_en, absorbs its
//  1-cycle registered read latency, and presents the bytes as a valid/ready stream.
//  A small skid buffer lets the downstream sink stall without losing in-flight reads,
//  and still sustains one byte per cycle when the sink is always ready.

---
 rtl/fifo_stream_reader_if.sv | 22 ++
 rtl/fifo_stream_reader.sv | 73 +++++++
 tb/tb_fifo_stream_reader.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
// Bundles the FIFO read port and the outgoing byte stream of fifo_stream_reader.
// master: the reader side (drives rd_en and the stream); slave: FIFO + sink side.
interface fifo_stream_reader_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd_en;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_rd_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_rd_en, m_valid, m_data
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the synchronous FIFO: issues rd_en, absorbs the one-cycle
// registered read latency and re-presents bytes as a valid/ready stream through a
// small circular skid buffer, so a stalled sink never loses an in-flight byte.
module fifo_stream_reader #(
  parameter int DATA_W     = 8,
  parameter int SKID_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  fifo_stream_reader_if.master bus,
  output logic [CNT_W-1:0]     xfer_count
);

  localparam int IDX_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int OCC_W = $clog2(SKID_DEPTH + 1);
  localparam int LVL_W = OCC_W + 1;

  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(SKID_DEPTH - 1);

  logic [DATA_W-1:0] skid_mem [SKID_DEPTH];
  idx_t              wr_idx;
  idx_t              rd_idx;
  logic [OCC_W-1:0]  cnt;
  logic              inflight;
  logic              pop;
  logic [LVL_W-1:0]  level;

  function automatic idx_t next_idx(input idx_t i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  // Stream outputs, pop detection and the read request. level is the occupancy
  // after this edge counting the byte already in flight, so a read is only issued
  // when a slot is guaranteed to be free when its data lands.
  always_comb begin
    bus.m_valid    = (cnt != '0);
    bus.m_data     = skid_mem[rd_idx];
    pop            = bus.m_valid & bus.m_ready;
    level          = LVL_W'(cnt) + LVL_W'(inflight) - LVL_W'(pop);
    bus.fifo_rd_en = rstn & ~bus.fifo_empty & (level < LVL_W'(SKID_DEPTH));
  end

  // Control state: occupancy, ring indices, in-flight flag and transfer counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt        <= '0;
      wr_idx     <= '0;
      rd_idx     <= '0;
      inflight   <= 1'b0;
      xfer_count <= '0;
    end else begin
      inflight <= bus.fifo_rd_en;
      cnt      <= level[OCC_W-1:0];
      if (inflight) begin
        wr_idx <= next_idx(wr_idx);
      end
      if (pop) begin
        rd_idx     <= next_idx(rd_idx);
        xfer_count <= xfer_count + 1'b1;
      end
    end
  end

  // Skid storage is left unreset; a slot is written only when a read is in flight.
  always_ff @(posedge clk) begin
    if (rstn && inflight) begin
      skid_mem[wr_idx] <= bus.fifo_data;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a FIFO model feeds the reader, a queue-based
// reference model predicts rd_en / m_valid / m_data / xfer_count every cycle,
// and directed windows pin literal expectations for each scenario.
module tb_fifo_stream_reader;

  logic        clk;
  logic        rstn;
  logic        m_ready;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic [15:0] xfer_count;
  logic [3:0]  xfer_count4;

  fifo_stream_reader_if #(.DATA_W(8)) bus  ();
  fifo_stream_reader_if #(.DATA_W(8)) bus4 ();

  assign bus.fifo_empty  = fifo_empty;
  assign bus.fifo_data   = fifo_data;
  assign bus.m_ready     = m_ready;
  assign bus4.fifo_empty = fifo_empty;
  assign bus4.fifo_data  = fifo_data;
  assign bus4.m_ready    = m_ready;

  fifo_stream_reader #(.DATA_W(8), .SKID_DEPTH(2), .CNT_W(16)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .xfer_count (xfer_count)
  );

  fifo_stream_reader #(.DATA_W(8), .SKID_DEPTH(2), .CNT_W(4)) dut4 (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus4),
    .xfer_count (xfer_count4)
  );

  always #5 clk = ~clk;

  // FIFO contents, reference model state and observation records
  logic [7:0]  src_q[$];
  logic [7:0]  model_q[$];
  logic [7:0]  got[$];
  logic [7:0]  sent[$];
  int          occ;
  int          pend;
  int unsigned pops;
  int          cyc;
  int          checks;
  int          errors;

  logic        s_rd;
  logic        s_valid;
  logic [7:0]  s_data;
  logic [15:0] s_xfer;
  logic [3:0]  s_xfer4;
  int          n_rd;
  int          n_valid;
  int          first_rd;
  int          last_rd;
  int          first_valid;
  int          last_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    return (got.size() > i) ? 32'(got[i]) : 32'hFFFF_FFFF;
  endfunction

  // One clock cycle: sample settled outputs, compare against the reference model,
  // then let the FIFO model and the reference model advance across the edge.
  task automatic tick();
    logic       exp_valid;
    logic       exp_rd;
    logic       pop_m;
    int         lvl;
    logic [7:0] nxt;
    logic       load;
    fifo_empty = (src_q.size() == 0);
    #1;
    exp_valid = (occ != 0);
    pop_m     = exp_valid && m_ready;
    lvl       = occ + pend - (pop_m ? 1 : 0);
    exp_rd    = rstn && !fifo_empty && (lvl < 2);

    s_rd    = bus.fifo_rd_en;
    s_valid = bus.m_valid;
    s_data  = bus.m_data;
    s_xfer  = xfer_count;
    s_xfer4 = xfer_count4;

    chk("rd_en", 32'(s_rd), 32'(exp_rd));
    chk("m_valid", 32'(s_valid), 32'(exp_valid));
    if (exp_valid) chk("m_data", 32'(s_data), 32'(model_q[0]));
    chk("xfer_count", 32'(s_xfer), pops & 32'hFFFF);
    chk("xfer_count_w4", 32'(s_xfer4), pops % 16);
    chk("rd_en_w4", 32'(bus4.fifo_rd_en), 32'(exp_rd));
    chk("occupancy_le_2", 32'(dut.cnt <= 2'd2), 32'd1);

    if (exp_rd) model_q.push_back(src_q[0]);
    load = 1'b0;
    nxt  = 8'h00;
    if (s_rd && src_q.size() != 0) begin
      nxt  = src_q.pop_front();
      load = 1'b1;
    end
    if (rstn && s_valid && m_ready) got.push_back(s_data);
    if (s_rd) begin
      n_rd++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
    end
    if (s_valid) begin
      n_valid++;
      if (first_valid < 0) first_valid = cyc;
      last_valid = cyc;
    end

    if (!rstn) begin
      occ  = 0;
      pend = 0;
      pops = 0;
      model_q.delete();
    end else begin
      if (pop_m) begin
        void'(model_q.pop_front());
        pops++;
      end
      occ  = occ + pend - (pop_m ? 1 : 0);
      pend = exp_rd ? 1 : 0;
    end

    @(posedge clk);
    #1;
    if (load) fifo_data = nxt;
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr();
    n_rd        = 0;
    n_valid     = 0;
    first_rd    = -1;
    last_rd     = -1;
    first_valid = -1;
    last_valid  = -1;
    got.delete();
  endtask

  initial begin
    int bad;
    int guard;
    clk        = 1'b0;
    rstn       = 1'b0;
    m_ready    = 1'b1;
    fifo_data  = 8'h00;
    fifo_empty = 1'b1;
    occ        = 0;
    pend       = 0;
    pops       = 0;
    cyc        = 0;
    checks     = 0;
    errors     = 0;
    src_q.push_back(8'hA5);
    @(negedge clk);

    // Reset held with a non-empty FIFO: no reads, nothing valid
    clr();
    run(3);
    chk("t1_rd_pulses", 32'(n_rd), 32'd0);
    chk("t1_valid_cycles", 32'(n_valid), 32'd0);
    chk("t1_xfer", 32'(s_xfer), 32'd0);

    // Single byte 0xA5
    rstn = 1'b1;
    clr();
    run(6);
    chk("t2_rd_pulses", 32'(n_rd), 32'd1);
    chk("t2_valid_cycles", 32'(n_valid), 32'd1);
    chk("t2_latency", 32'(first_valid - first_rd), 32'd2);
    chk("t2_count", 32'(got.size()), 32'd1);
    chk("t2_byte", got_at(0), 32'hA5);
    chk("t2_xfer", 32'(s_xfer), 32'd1);

    // Four-byte stream, sink always ready
    clr();
    for (int i = 1; i <= 4; i++) src_q.push_back(8'(i));
    run(8);
    chk("t3_rd_pulses", 32'(n_rd), 32'd4);
    chk("t3_rd_span", 32'(last_rd - first_rd), 32'd3);
    chk("t3_valid_cycles", 32'(n_valid), 32'd4);
    chk("t3_valid_span", 32'(last_valid - first_valid), 32'd3);
    for (int i = 0; i < 4; i++) chk("t3_byte", got_at(i), 32'(i + 1));
    chk("t3_xfer", 32'(s_xfer), 32'd5);

    // Backpressure: only two reads outstanding, head byte held
    clr();
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) src_q.push_back(8'(i));
    run(6);
    chk("t4_rd_pulses_stalled", 32'(n_rd), 32'd2);
    chk("t4_valid_held", 32'(s_valid), 32'd1);
    chk("t4_data_held", 32'(s_data), 32'h01);
    chk("t4_no_pops", 32'(got.size()), 32'd0);
    m_ready = 1'b1;
    clr();
    run(8);
    chk("t4_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t4_byte", got_at(i), 32'(i + 1));
    chk("t4_rd_pulses_release", 32'(n_rd), 32'd2);
    chk("t4_xfer", 32'(s_xfer), 32'd9);

    // Mid-stream reset with a buffered byte and one in flight
    clr();
    for (int i = 0; i < 4; i++) src_q.push_back(8'h11 + 8'(i));
    run(3);
    rstn = 1'b0;
    src_q.delete();
    run(1);
    rstn = 1'b1;
    run(1);
    chk("t6_valid_after_reset", 32'(s_valid), 32'd0);
    chk("t6_xfer_after_reset", 32'(s_xfer), 32'd0);
    clr();
    src_q.push_back(8'h5A);
    run(6);
    chk("t6_count", 32'(got.size()), 32'd1);
    chk("t6_byte", got_at(0), 32'h5A);
    chk("t6_xfer", 32'(s_xfer), 32'd1);

    // 64 random bytes with a randomly stalling sink
    clr();
    sent.delete();
    for (int i = 0; i < 64; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      sent.push_back(b);
      src_q.push_back(b);
    end
    guard = 0;
    while (got.size() < 64 && guard < 3000) begin
      m_ready = ($urandom_range(0, 3) != 0);
      run(1);
      guard++;
    end
    chk("t5_all_received", 32'(got.size()), 32'd64);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (got_at(i) !== 32'(sent[i])) bad++;
    end
    chk("t5_order", 32'(bad), 32'd0);
    m_ready = 1'b1;
    run(2);
    chk("t5_xfer", 32'(s_xfer), 32'd65);
    chk("t5_xfer_w4_wrap", 32'(s_xfer4), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
